// File: rtl/bus_pkg.sv
// Shared sizing helpers for the round-robin bus arbiter and its ID tracking FIFO.
// Pure compile-time content: no logic, no latency.
// Not applicable to flow control; consumers derive their own widths from these.
package bus_pkg;

    // Host ID width; a single host still needs a one-bit ID to index arrays.
    function automatic int id_width(input int n_hosts);
        return (n_hosts > 1) ? $clog2(n_hosts) : 1;
    endfunction

    // Width of a counter able to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Host ID type for the default two-host configuration.
    localparam int DefaultNrHosts  = 2;
    localparam int DefaultIdWidth  = id_width(DefaultNrHosts);
    typedef logic [DefaultIdWidth-1:0] host_id_t;

endpackage

// File: rtl/bus_rr_arbiter_fifo.sv
// In-order FIFO of host IDs for requests that have been accepted but not yet answered.
// Push and pop take effect at the clock edge; the head and count are registered.
// No internal stall: a push while full and a pop while empty are ignored, and the owner never issues either.
module bus_id_fifo
    import bus_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 1,
    parameter int CntW  = cnt_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CntW'(Depth));
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin share of one downstream req/gnt/rvalid port among NrHosts hosts, with in-order response routing.
// Zero cycles: grant and response routing are combinational in the handshake/response cycle.
// A stalled downstream request is locked to its host until granted; issue stops at MaxOutstanding tracked requests.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                       host_err_o,
    output logic                                     dev_req_o,
    input  logic                                     dev_gnt_i,
    output logic [AddressWidth-1:0]                  dev_addr_o,
    output logic                                     dev_we_o,
    output logic [DataWidth/8-1:0]                   dev_be_o,
    output logic [DataWidth-1:0]                     dev_wdata_o,
    input  logic                                     dev_rvalid_i,
    input  logic [DataWidth-1:0]                     dev_rdata_i,
    input  logic                                     dev_err_i,
    output logic [cnt_width(MaxOutstanding)-1:0]     outstanding_o,
    output logic                                     spurious_rsp_o
);
    localparam int IdW  = id_width(NrHosts);
    localparam int CntW = cnt_width(MaxOutstanding);

    logic [IdW-1:0]  r_rr_ptr;
    logic            r_lock;
    logic [IdW-1:0]  r_lock_id;

    logic [IdW-1:0]  w_rr_sel;
    logic            w_rr_found;
    logic [IdW-1:0]  w_sel;
    logic            w_can_issue;
    logic            w_hs;
    logic            w_pop;
    logic [IdW-1:0]  w_head;
    logic [CntW-1:0] w_count;
    logic            w_empty;
    logic            w_full;

    // Round-robin scan starting just after the last granted host.
    always_comb begin
        w_rr_sel   = r_rr_ptr;
        w_rr_found = 1'b0;
        for (int k = 1; k <= NrHosts; k++) begin
            if (!w_rr_found && host_req_i[IdW'((int'(r_rr_ptr) + k) % NrHosts)]) begin
                w_rr_sel   = IdW'((int'(r_rr_ptr) + k) % NrHosts);
                w_rr_found = 1'b1;
            end
        end
    end

    // A stalled downstream request keeps its host so the bus request stays stable.
    assign w_sel       = r_lock ? r_lock_id : w_rr_sel;
    // Full means no slot; a response in the same cycle does not free one early.
    assign w_can_issue = ~w_full;
    assign dev_req_o   = w_can_issue & ((|host_req_i) | r_lock);
    assign w_hs        = dev_req_o & dev_gnt_i;
    assign w_pop       = dev_rvalid_i & ~w_empty;
    assign spurious_rsp_o = dev_rvalid_i & w_empty;
    assign outstanding_o  = w_count;

    assign dev_addr_o  = dev_req_o ? host_addr_i[w_sel]  : '0;
    assign dev_we_o    = dev_req_o ? host_we_i[w_sel]    : 1'b0;
    assign dev_be_o    = dev_req_o ? host_be_i[w_sel]    : '0;
    assign dev_wdata_o = dev_req_o ? host_wdata_i[w_sel] : '0;

    // Grant goes only to the selected host, and only on a downstream handshake.
    always_comb begin
        host_gnt_o = '0;
        if (w_hs) host_gnt_o[w_sel] = 1'b1;
    end

    // Responses are steered to the host at the head of the tracking FIFO.
    always_comb begin
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        if (w_pop) begin
            host_rvalid_o[w_head] = 1'b1;
            host_rdata_o[w_head]  = dev_rdata_i;
            host_err_o[w_head]    = dev_err_i;
        end
    end

    // Arbitration state: pointer advances on handshake, lock holds a stalled request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr  <= IdW'(NrHosts - 1);
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= w_sel;
            r_lock   <= 1'b0;
        end else if (dev_req_o) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_sel;
        end
    end

    bus_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_hs),
        .push_data_i (w_sel),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .empty_o     (w_empty),
        .full_o      (w_full)
    );

    for (genvar g = 0; g < NrHosts; g++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (host_req_i[g] && !host_gnt_o[g]) |=> host_req_i[g])
            else $warning("host %0d dropped req before gnt", g);
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;
    localparam int NH = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NH-1:0]          host_req;
    logic [NH-1:0]          host_gnt;
    logic [NH-1:0][AW-1:0]  host_addr;
    logic [NH-1:0]          host_we;
    logic [NH-1:0][DW/8-1:0] host_be;
    logic [NH-1:0][DW-1:0]  host_wdata;
    logic [NH-1:0]          host_rvalid;
    logic [NH-1:0][DW-1:0]  host_rdata;
    logic [NH-1:0]          host_err;
    logic                   dev_req;
    logic                   dev_gnt;
    logic [AW-1:0]          dev_addr;
    logic                   dev_we;
    logic [DW/8-1:0]        dev_be;
    logic [DW-1:0]          dev_wdata;
    logic                   dev_rvalid;
    logic [DW-1:0]          dev_rdata;
    logic                   dev_err;
    logic [CW-1:0]          outstanding;
    logic                   spurious;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
        .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .outstanding_o(outstanding), .spurious_rsp_o(spurious)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NH; i++) begin
            host_addr[i]  = 32'h1000 + 32'(i * 16);
            host_we[i]    = 1'(i % 2);
            host_be[i]    = 4'(15 - i);
            host_wdata[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic idle_inputs();
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step();
        rst_n = 1'b0;
        idle_inputs();
        set_addrs();
        step();
        rst_n = 1'b1;
    endtask

    // First requester scanning last+1, last+2, ... modulo NH; -1 if none.
    function automatic int pick(input logic [NH-1:0] req, input int last);
        for (int k = 1; k <= NH; k++) begin
            if (req[(last + k) % NH]) return (last + k) % NH;
        end
        return -1;
    endfunction

    typedef struct {
        logic [NH-1:0] req;
        logic          gnt;
        logic          rv;
        logic [NH-1:0] exp_gnt;
        logic          exp_req;
        int            exp_sel;
        logic          exp_spur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Single-cycle behaviour straight out of reset (pointer at NH-1, FIFO empty).
        vecs[0] = '{req:3'b000, gnt:1'b1, rv:1'b0, exp_gnt:3'b000, exp_req:1'b0, exp_sel:0, exp_spur:1'b0};
        vecs[1] = '{req:3'b001, gnt:1'b1, rv:1'b0, exp_gnt:3'b001, exp_req:1'b1, exp_sel:0, exp_spur:1'b0};
        vecs[2] = '{req:3'b010, gnt:1'b1, rv:1'b0, exp_gnt:3'b010, exp_req:1'b1, exp_sel:1, exp_spur:1'b0};
        vecs[3] = '{req:3'b110, gnt:1'b1, rv:1'b0, exp_gnt:3'b010, exp_req:1'b1, exp_sel:1, exp_spur:1'b0};
        vecs[4] = '{req:3'b111, gnt:1'b1, rv:1'b0, exp_gnt:3'b001, exp_req:1'b1, exp_sel:0, exp_spur:1'b0};
        vecs[5] = '{req:3'b100, gnt:1'b0, rv:1'b0, exp_gnt:3'b000, exp_req:1'b1, exp_sel:2, exp_spur:1'b0};
        vecs[6] = '{req:3'b000, gnt:1'b0, rv:1'b1, exp_gnt:3'b000, exp_req:1'b0, exp_sel:0, exp_spur:1'b1};
        vecs[7] = '{req:3'b101, gnt:1'b1, rv:1'b1, exp_gnt:3'b001, exp_req:1'b1, exp_sel:0, exp_spur:1'b1};

        idle_inputs();
        set_addrs();

        for (int v = 0; v < 8; v++) begin
            reset_dut();
            chk($sformatf("v%0d_rst_outstanding", v), 64'(outstanding), 64'd0);
            host_req   = vecs[v].req;
            dev_gnt    = vecs[v].gnt;
            dev_rvalid = vecs[v].rv;
            dev_rdata  = 32'h55AA_0000 + 32'(v);
            #1;
            chk($sformatf("v%0d_gnt", v), 64'(host_gnt), 64'(vecs[v].exp_gnt));
            chk($sformatf("v%0d_dev_req", v), 64'(dev_req), 64'(vecs[v].exp_req));
            chk($sformatf("v%0d_dev_addr", v), 64'(dev_addr),
                vecs[v].exp_req ? 64'(host_addr[vecs[v].exp_sel]) : 64'd0);
            chk($sformatf("v%0d_spurious", v), 64'(spurious), 64'(vecs[v].exp_spur));
            chk($sformatf("v%0d_rvalid", v), 64'(host_rvalid), 64'd0);
        end

        // Single host read with three-cycle response latency.
        reset_dut();
        host_addr[0] = 32'h100;
        host_we[0]   = 1'b0;
        host_req     = 3'b001;
        dev_gnt      = 1'b1;
        #1;
        chk("A_gnt", 64'(host_gnt), 64'b001);
        chk("A_addr", 64'(dev_addr), 64'h100);
        chk("A_we", 64'(dev_we), 64'd0);
        step();
        host_req = '0;
        dev_gnt  = 1'b0;
        #1;
        chk("A_out1", 64'(outstanding), 64'd1);
        step();
        step();
        dev_rvalid = 1'b1;
        dev_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("A_rvalid", 64'(host_rvalid), 64'b001);
        chk("A_rdata0", 64'(host_rdata[0]), 64'hDEAD_BEEF);
        chk("A_rdata1", 64'(host_rdata[1]), 64'd0);
        step();
        dev_rvalid = 1'b0;
        #1;
        chk("A_out0", 64'(outstanding), 64'd0);

        // Back-pressure lock: host1 stalls, host0 arrives mid-stall.
        reset_dut();
        host_req = 3'b010;
        dev_gnt  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) host_req = 3'b011;
            #1;
            chk($sformatf("B_addr_c%0d", c), 64'(dev_addr), 64'(host_addr[1]));
            chk($sformatf("B_nogrant_c%0d", c), 64'(host_gnt), 64'd0);
            step();
        end
        dev_gnt = 1'b1;
        #1;
        chk("B_gnt_first", 64'(host_gnt), 64'b010);
        step();
        host_req = 3'b001;
        #1;
        chk("B_gnt_second", 64'(host_gnt), 64'b001);
        chk("B_addr_second", 64'(dev_addr), 64'(host_addr[0]));

        // Outstanding limit and same-cycle pop not freeing a slot.
        reset_dut();
        dev_gnt  = 1'b1;
        host_req = 3'b001;
        step();
        host_req = 3'b010;
        #1;
        chk("C_gnt2", 64'(host_gnt), 64'b010);
        step();
        host_req = 3'b001;
        #1;
        chk("C_full_req", 64'(dev_req), 64'd0);
        chk("C_full_gnt", 64'(host_gnt), 64'd0);
        chk("C_full_out", 64'(outstanding), 64'd2);
        step();
        dev_rvalid = 1'b1;
        #1;
        chk("C_pop_rv", 64'(host_rvalid), 64'b001);
        chk("C_pop_req", 64'(dev_req), 64'd0);
        step();
        dev_rvalid = 1'b0;
        #1;
        chk("C_resume_req", 64'(dev_req), 64'd1);
        chk("C_resume_gnt", 64'(host_gnt), 64'b001);
        chk("C_resume_out", 64'(outstanding), 64'd1);

        // Push and pop in the same cycle.
        reset_dut();
        dev_gnt  = 1'b1;
        host_req = 3'b001;
        step();
        host_req   = 3'b010;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h11;
        #1;
        chk("D_gnt", 64'(host_gnt), 64'b010);
        chk("D_rv_old", 64'(host_rvalid), 64'b001);
        chk("D_rdata_old", 64'(host_rdata[0]), 64'h11);
        step();
        host_req  = '0;
        dev_gnt   = 1'b0;
        dev_rdata = 32'h22;
        #1;
        chk("D_out_same", 64'(outstanding), 64'd1);
        chk("D_rv_new", 64'(host_rvalid), 64'b010);
        chk("D_rdata_new", 64'(host_rdata[1]), 64'h22);
        step();
        dev_rvalid = 1'b0;
        #1;
        chk("D_out_drained", 64'(outstanding), 64'd0);

        // Reset with two outstanding, then a late response.
        reset_dut();
        dev_gnt  = 1'b1;
        host_req = 3'b001;
        step();
        host_req = 3'b010;
        step();
        host_req = '0;
        dev_gnt  = 1'b0;
        #1;
        chk("E_out2", 64'(outstanding), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("E_rst_out", 64'(outstanding), 64'd0);
        step();
        rst_n      = 1'b1;
        dev_rvalid = 1'b1;
        #1;
        chk("E_spur", 64'(spurious), 64'd1);
        chk("E_no_rv", 64'(host_rvalid), 64'd0);
        chk("E_out_after", 64'(outstanding), 64'd0);
        step();
        dev_rvalid = 1'b0;
        #1;
        chk("E_spur_off", 64'(spurious), 64'd0);

        // Fairness: hosts 0 and 1 always requesting, a response every cycle after the first.
        reset_dut();
        host_req = 3'b011;
        dev_gnt  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            dev_rvalid = (c > 0);
            #1;
            chk($sformatf("F_gnt_c%0d", c), 64'(host_gnt), (c % 2 == 0) ? 64'b001 : 64'b010);
            chk($sformatf("F_rv_c%0d", c), 64'(host_rvalid),
                (c == 0) ? 64'd0 : ((c % 2 == 1) ? 64'b001 : 64'b010));
            step();
        end

        // Randomized traffic against a queue-based reference model.
        reset_dut();
        begin
            int            q[$];
            int            last;
            bit            locked;
            int            lock_id;
            int            sel;
            int            head;
            bit            ereq;
            bit            hs;
            bit            pop;
            logic [NH-1:0] rreq;
            logic [NH-1:0] again;
            last   = NH - 1;
            locked = 1'b0;
            lock_id = 0;
            rreq   = '0;
            again  = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                for (int i = 0; i < NH; i++) begin
                    if (!rreq[i] && (again[i] || $urandom_range(0, 2) == 0)) begin
                        rreq[i]       = 1'b1;
                        host_addr[i]  = $urandom;
                        host_we[i]    = 1'($urandom_range(0, 1));
                        host_be[i]    = 4'($urandom_range(0, 15));
                        host_wdata[i] = $urandom;
                    end
                end
                again      = '0;
                host_req   = rreq;
                dev_gnt    = ($urandom_range(0, 9) < 6);
                dev_rvalid = ($urandom_range(0, 2) == 0);
                dev_rdata  = $urandom;
                dev_err    = 1'($urandom_range(0, 1));
                #1;
                sel  = locked ? lock_id : pick(rreq, last);
                ereq = (q.size() < MO) && ((rreq != '0) || locked);
                hs   = ereq && dev_gnt;
                pop  = dev_rvalid && (q.size() > 0);
                head = pop ? q[0] : 0;
                chk("R_dev_req", 64'(dev_req), 64'(ereq));
                chk("R_gnt", 64'(host_gnt), hs ? (64'd1 << sel) : 64'd0);
                chk("R_addr", 64'(dev_addr), ereq ? 64'(host_addr[sel]) : 64'd0);
                chk("R_we_be_wdata", {27'd0, dev_we, dev_be, dev_wdata},
                    ereq ? {27'd0, host_we[sel], host_be[sel], host_wdata[sel]} : 64'd0);
                chk("R_rvalid", 64'(host_rvalid), pop ? (64'd1 << head) : 64'd0);
                chk("R_err", 64'(host_err), (pop && dev_err) ? (64'd1 << head) : 64'd0);
                for (int i = 0; i < NH; i++) begin
                    chk($sformatf("R_rdata%0d", i), 64'(host_rdata[i]),
                        (pop && head == i) ? 64'(dev_rdata) : 64'd0);
                end
                chk("R_spurious", 64'(spurious), 64'(dev_rvalid && q.size() == 0));
                chk("R_outstanding", 64'(outstanding), 64'(q.size()));
                if (pop) void'(q.pop_front());
                if (hs) begin
                    q.push_back(sel);
                    last       = sel;
                    locked     = 1'b0;
                    rreq[sel]  = 1'b0;
                    again[sel] = 1'($urandom_range(0, 1));
                end else if (ereq) begin
                    locked  = 1'b1;
                    lock_id = sel;
                end
                step();
            end
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Shares one downstream device port between NrHosts Ibex-protocol hosts (req/gnt/rvalid), using fair round-robin arbitration. The downstream port may accept requests with back-pressure (gnt) and may return responses with variable latency, in order. Each accepted request's host ID is recorded in an in-order tracking FIFO so that every response is routed to the host that issued it. The block sits between the core/debug hosts and the bus fabric, replacing the fixed-priority, one-cycle-response host select.

Parameters:
NrHosts, 2, number of requesting hosts (>=1)
DataWidth, 32, data bus width in bits
AddressWidth, 32, address width in bits
MaxOutstanding, 2, maximum accepted-but-unanswered requests (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_req_i  in  1 [NrHosts]  host request, held until granted
host_gnt_o  out  1 [NrHosts]  request accepted this cycle
host_addr_i  in  AddressWidth [NrHosts]  address
host_we_i  in  1 [NrHosts]  write enable
host_be_i  in  DataWidth/8 [NrHosts]  byte enables
host_wdata_i  in  DataWidth [NrHosts]  write data
host_rvalid_o  out  1 [NrHosts]  response valid
host_rdata_o  out  DataWidth [NrHosts]  read data
host_err_o  out  1 [NrHosts]  error response
dev_req_o  out  1  downstream request
dev_gnt_i  in  1  downstream accept
dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  as host  forwarded from selected host
dev_rvalid_i  in  1  downstream response valid (in order)
dev_rdata_i  in  DataWidth  response data
dev_err_i  in  1  response error
outstanding_o  out  $clog2(MaxOutstanding+1)  current tracked count
spurious_rsp_o  out  1  one-cycle pulse: dev_rvalid_i arrived with FIFO empty

Behaviour:
- Reset (async, rst_ni=0): rr_ptr_q=NrHosts-1, so host 0 wins first; lock_q=0; FIFO empty; outstanding_o=0; spurious_rsp_o=0. All combinational outputs are 0 while no requests are pending.
- can_issue = (count < MaxOutstanding). Same-cycle pop does not free a slot.
- Selection when unlocked: first requesting host scanning rr_ptr_q+1, +2, ... modulo NrHosts.
- dev_req_o = can_issue & (any host_req_i | lock_q). Forwarded addr/we/be/wdata come from sel; they are 0 when dev_req_o=0.
- Lock: if dev_req_o=1 and dev_gnt_i=0, then lock_q<=1 and lock_id_q<=sel. While locked, sel=lock_id_q and no re-arbitration occurs, so the downstream request stays stable. The lock clears on the handshake.
- Handshake (dev_req_o & dev_gnt_i): host_gnt_o[sel]=1, combinationally in the same cycle. Push sel into the FIFO; rr_ptr_q<=sel; lock_q<=0.
- host_gnt_o is 0 for all non-selected hosts, and for all hosts when can_issue=0.
- Response: on dev_rvalid_i with FIFO non-empty, the FIFO head ID h receives host_rvalid_o[h]=1 and the rdata/err are forwarded; then pop. Response latency through the block is 0 cycles. Non-selected hosts see rvalid/rdata/err = 0.
- dev_rvalid_i with FIFO empty: routed nowhere, spurious_rsp_o=1 for that cycle, count unchanged.
- Simultaneous push and pop: count unchanged; the head advances and the new ID is written at the tail. A push into a FIFO that is empty in the same cycle as a pop cannot occur, because a pop requires count>=1.
- Back-to-back: one handshake is allowed per cycle. A host holding req after its gnt is a new request, and round-robin then favours other requesters.
- Pointer wrap: indices wrap modulo NrHosts. NrHosts not a power of 2 must work (e.g., 3).
- Reset mid-operation: tracked IDs are discarded. Late responses after reset raise spurious_rsp_o.
- Assertions: host_req_i must not drop before gnt (warning only). The FIFO never overflows.

Decomposition:
- Package bus_pkg: function for the ID width (max(1,$clog2(NrHosts))), the count-width localparam, and a typedef for the host ID.
- Sub-module bus_id_fifo: synchronous FIFO with depth MaxOutstanding and width ID. It exposes push, pop, head, count, empty and full, and supports push and pop in the same cycle.
- The arbiter top holds rr_ptr_q, lock_q/lock_id_q and the routing muxes.

Test Plan:
- Single host: host0 reads 0x100, dev_gnt_i=1, rvalid 3 cycles later with rdata=0xDEADBEEF → host_gnt_o[0] in the request cycle; host_rvalid_o[0]=1 with 0xDEADBEEF; outstanding_o goes 1→0.
- Fairness: both hosts hold req continuously, dev_gnt_i=1, MaxOutstanding=4, responses every cycle → grants alternate 0,1,0,1 and every response lands on the correct host.
- Back-pressure lock: host1 requests with dev_gnt_i=0 for 3 cycles, and host0 raises req in cycle 2 → dev_addr_o stays at host1's address; host1 is granted first, host0 next.
- Outstanding limit: MaxOutstanding=2, two grants and no rvalid → the third request sees dev_req_o=0 and no gnt; one rvalid → issue resumes next cycle.
- Push and pop in the same cycle: count=1, new handshake plus rvalid in the same cycle → outstanding_o stays 1; the old head is answered first, then the new ID.
- Spurious/reset: assert rst_ni=0 with 2 outstanding, then rvalid after reset release → no host_rvalid_o; spurious_rsp_o pulses once.
